// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared memory-bus widths and data-RAM arbiter encodings.
package dmem_arbiter_pkg;
  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_UNIT_W     = MEM_DATA_W / 8;
  localparam int DBG_STARVE_MAX = 4;
  typedef enum logic {ARB_CORE = 1'b0, ARB_LOCK = 1'b1} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CORE = 2'd1, OWN_DBG = 2'd2} owner_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the core data port and a debug master,
// core-priority with a starvation bound and a debug lock for bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = DBG_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_cs_i,
  input  logic                core_we_i,
  input  logic [DATA_W/8-1:0] core_wem_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_din_i,
  output logic                core_hold_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_dout_o,
  input  logic                dbg_cs_i,
  input  logic                dbg_we_i,
  input  logic [DATA_W/8-1:0] dbg_wem_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  input  logic [DATA_W-1:0]   dbg_din_i,
  input  logic                dbg_lock_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [DATA_W-1:0]   dbg_dout_o,
  output logic                ram_cs_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_wem_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_din_o,
  input  logic [DATA_W-1:0]   ram_dout_i
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  arb_state_t       state;
  owner_t           rd_owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved, core_gnt, dbg_gnt;
  // grants are masked during reset so the RAM is idle immediately
  assign starved     = starve_cnt == CNT_W'(STARVE_MAX);
  assign core_gnt    = !rst && state == ARB_CORE && core_cs_i && !(dbg_cs_i && starved);
  assign dbg_gnt     = !rst && dbg_cs_i && (state == ARB_LOCK || !core_cs_i || starved);
  assign core_hold_o = core_cs_i & ~core_gnt;
  assign dbg_gnt_o   = dbg_gnt;
  assign ram_cs_o    = core_gnt | dbg_gnt;
  assign ram_we_o    = core_gnt ? core_we_i : dbg_gnt & dbg_we_i;
  assign ram_wem_o   = core_gnt ? core_wem_i : dbg_gnt ? dbg_wem_i : '0;
  assign ram_addr_o  = core_gnt ? core_addr_i : dbg_gnt ? dbg_addr_i : '0;
  assign ram_din_o   = core_gnt ? core_din_i : dbg_gnt ? dbg_din_i : '0;
  assign core_rvalid_o = rd_owner == OWN_CORE;
  assign dbg_rvalid_o  = rd_owner == OWN_DBG;
  assign core_dout_o   = core_rvalid_o ? ram_dout_i : '0;
  assign dbg_dout_o    = dbg_rvalid_o ? ram_dout_i : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARB_CORE;
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (dbg_gnt) starve_cnt <= '0;
      else if (dbg_cs_i && core_gnt && !starved) starve_cnt <= starve_cnt + 1'b1;
      state    <= state == ARB_CORE ? (dbg_gnt && dbg_lock_i ? ARB_LOCK : ARB_CORE)
                                    : (dbg_lock_i ? ARB_LOCK : ARB_CORE);
      rd_owner <= core_gnt && !core_we_i ? OWN_CORE : dbg_gnt && !dbg_we_i ? OWN_DBG : OWN_NONE;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
  localparam int SM = 4;
  logic        clk = 0, rst = 0;
  logic        core_cs_i = 0, core_we_i = 0, dbg_cs_i = 0, dbg_we_i = 0, dbg_lock_i = 0;
  logic [3:0]  core_wem_i = 0, dbg_wem_i = 0;
  logic [31:0] core_addr_i = 0, core_din_i = 0, dbg_addr_i = 0, dbg_din_i = 0;
  logic        core_hold_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o, ram_cs_o, ram_we_o;
  logic [3:0]  ram_wem_o;
  logic [31:0] core_dout_o, dbg_dout_o, ram_addr_o, ram_din_o, ram_dout_i;
  int          checks = 0, failures = 0;
  bit [31:0]   ram_mem [16];
  bit [31:0]   shadow [16];
  int          lost = 0, pend = 0, w;
  bit          locked = 0, c_keep, d_keep;
  bit [31:0]   pend_data = 0;
  logic [9:0]  gpat, hpat;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .core_cs_i(core_cs_i), .core_we_i(core_we_i), .core_wem_i(core_wem_i),
    .core_addr_i(core_addr_i), .core_din_i(core_din_i), .core_hold_o(core_hold_o),
    .core_rvalid_o(core_rvalid_o), .core_dout_o(core_dout_o),
    .dbg_cs_i(dbg_cs_i), .dbg_we_i(dbg_we_i), .dbg_wem_i(dbg_wem_i),
    .dbg_addr_i(dbg_addr_i), .dbg_din_i(dbg_din_i), .dbg_lock_i(dbg_lock_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_dout_o(dbg_dout_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_wem_o(ram_wem_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  // RAM environment: synchronous-read, byte-masked write, 16 words
  always @(posedge clk)
    if (ram_cs_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem_o[b]) ram_mem[ram_addr_o[5:2]][8*b +: 8] <= ram_din_o[8*b +: 8];
      end else ram_dout_i <= ram_mem[ram_addr_o[5:2]];
    end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: who wins this cycle, what the RAM sees, what reads return
  always @(negedge clk) begin
    bit cg, dg, we;
    logic [31:0] ad, dn;
    logic [3:0]  wm;
    if (rst) begin
      chk("rst_ram_cs", ram_cs_o, 0);
      chk("rst_core_rvalid", core_rvalid_o, 0);
      chk("rst_dbg_rvalid", dbg_rvalid_o, 0);
      lost = 0; locked = 0; pend = 0;
    end else begin
      if (locked) begin cg = 0; dg = dbg_cs_i; end
      else if (core_cs_i && dbg_cs_i) begin dg = lost >= SM; cg = !dg; end
      else begin cg = core_cs_i; dg = dbg_cs_i; end
      we = cg ? core_we_i : dbg_we_i;
      wm = cg ? core_wem_i : dbg_wem_i;
      ad = cg ? core_addr_i : dbg_addr_i;
      dn = cg ? core_din_i : dbg_din_i;
      chk("core_hold", core_hold_o, core_cs_i && !cg);
      chk("dbg_gnt", dbg_gnt_o, dg);
      chk("ram_cs", ram_cs_o, cg || dg);
      chk("ram_we", ram_we_o, (cg || dg) && we);
      chk("ram_wem", ram_wem_o, (cg || dg) ? wm : 4'h0);
      chk("ram_addr", ram_addr_o, (cg || dg) ? ad : 32'h0);
      chk("ram_din", ram_din_o, (cg || dg) ? dn : 32'h0);
      chk("core_rvalid", core_rvalid_o, pend == 1);
      chk("core_dout", core_dout_o, pend == 1 ? pend_data : 32'h0);
      chk("dbg_rvalid", dbg_rvalid_o, pend == 2);
      chk("dbg_dout", dbg_dout_o, pend == 2 ? pend_data : 32'h0);
      pend = 0;
      if (cg || dg) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (wm[b]) shadow[ad[5:2]][8*b +: 8] = dn[8*b +: 8];
        end else begin
          pend = cg ? 1 : 2;
          pend_data = shadow[ad[5:2]];
        end
      end
      if (dg) lost = 0;
      else if (dbg_cs_i && cg) lost = lost < SM ? lost + 1 : SM;
      locked = locked ? dbg_lock_i : dg && dbg_lock_i;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1;
    @(negedge clk);
    chk("reset_core_rvalid", core_rvalid_o, 0);
    chk("reset_dbg_rvalid", dbg_rvalid_o, 0);
    chk("reset_ram_cs", ram_cs_o, 0);
    nxt();
    rst = 0;
    // core-only write then read
    core_cs_i = 1; core_we_i = 1; core_wem_i = 4'hF; core_addr_i = 32'h10; core_din_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("core_wr_cs", ram_cs_o, 1);
    chk("core_wr_hold", core_hold_o, 0);
    nxt();
    core_we_i = 0;
    @(negedge clk);
    chk("core_rd_cs", ram_cs_o, 1);
    chk("core_wr_no_rvalid", core_rvalid_o, 0);
    nxt();
    core_cs_i = 0;
    @(negedge clk);
    chk("core_rd_rvalid", core_rvalid_o, 1);
    chk("core_rd_dout", core_dout_o, 32'hDEADBEEF);
    nxt();
    // contention: debug wins every fifth cycle
    core_cs_i = 1; core_we_i = 1; core_addr_i = 32'h30; core_din_i = 32'h11112222;
    dbg_cs_i = 1; dbg_we_i = 1; dbg_wem_i = 4'hF; dbg_addr_i = 32'h34; dbg_din_i = 32'h33334444;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gpat[i] = dbg_gnt_o;
      hpat[i] = core_hold_o;
      nxt();
    end
    chk("contend_dbg_gnt", gpat, 10'h210);
    chk("contend_core_hold", hpat, 10'h210);
    dbg_cs_i = 0;
    @(negedge clk);
    nxt();
    // lock burst while the core keeps requesting a read of 0x10
    core_we_i = 0; core_addr_i = 32'h10;
    dbg_cs_i = 1; dbg_lock_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h20; dbg_din_i = 32'hA5A50001;
    w = 0;
    forever begin
      @(negedge clk);
      if (dbg_gnt_o || w == 8) break;
      w++;
      nxt();
    end
    chk("lock_wait_cycles", w, 4);
    chk("lock_first_hold", core_hold_o, 1);
    nxt();
    dbg_addr_i = 32'h24; dbg_din_i = 32'h12345678;
    @(negedge clk);
    chk("lock_second_gnt", dbg_gnt_o, 1);
    chk("lock_second_hold", core_hold_o, 1);
    nxt();
    dbg_cs_i = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lock_idle_hold", core_hold_o, 1);
      chk("lock_idle_ram_cs", ram_cs_o, 0);
      nxt();
    end
    dbg_lock_i = 0;
    @(negedge clk);
    chk("unlock_sample_hold", core_hold_o, 1);
    nxt();
    @(negedge clk);
    chk("unlock_core_gnt", core_hold_o, 0);
    chk("unlock_ram_addr", ram_addr_o, 32'h10);
    nxt();
    // read return routing: core read returned now, debug read issued
    core_cs_i = 0;
    dbg_cs_i = 1; dbg_we_i = 0; dbg_addr_i = 32'h20;
    @(negedge clk);
    chk("route_core_rvalid", core_rvalid_o, 1);
    chk("route_core_dout", core_dout_o, 32'hDEADBEEF);
    chk("route_dbg_rvalid_lo", dbg_rvalid_o, 0);
    chk("route_dbg_dout_lo", dbg_dout_o, 0);
    nxt();
    dbg_cs_i = 0;
    @(negedge clk);
    chk("route_dbg_rvalid", dbg_rvalid_o, 1);
    chk("route_dbg_dout", dbg_dout_o, 32'hA5A50001);
    chk("route_core_rvalid_lo", core_rvalid_o, 0);
    chk("route_core_dout_lo", core_dout_o, 0);
    nxt();
    // reset in the middle of a lock with a debug read in flight
    dbg_cs_i = 1; dbg_lock_i = 1; dbg_addr_i = 32'h24;
    @(negedge clk);
    nxt();
    core_cs_i = 1; core_we_i = 0; core_addr_i = 32'h10; dbg_addr_i = 32'h20;
    @(negedge clk);
    chk("rstlock_core_hold", core_hold_o, 1);
    chk("rstlock_dbg_gnt", dbg_gnt_o, 1);
    nxt();
    chk("rstlock_inflight", dbg_rvalid_o, 1);
    #1 rst = 1;
    #1;
    chk("rstlock_dbg_rvalid", dbg_rvalid_o, 0);
    chk("rstlock_core_rvalid", core_rvalid_o, 0);
    chk("rstlock_ram_cs", ram_cs_o, 0);
    @(negedge clk);
    nxt();
    rst = 0; dbg_cs_i = 0; dbg_lock_i = 0;
    @(negedge clk);
    chk("post_rst_core_gnt", core_hold_o, 0);
    chk("post_rst_ram_cs", ram_cs_o, 1);
    nxt();
    core_cs_i = 0;
    // random traffic; masters hold a request until granted
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      c_keep = core_hold_o;
      d_keep = dbg_cs_i && !dbg_gnt_o;
      nxt();
      rst = $urandom_range(0, 199) == 0;
      if (!c_keep) begin
        core_cs_i   = $urandom_range(0, 2) != 0;
        core_we_i   = $urandom_range(0, 1) == 1;
        core_wem_i  = 4'($urandom);
        core_addr_i = 32'($urandom_range(0, 15)) << 2;
        core_din_i  = $urandom;
      end
      if (!d_keep) begin
        dbg_cs_i   = $urandom_range(0, 1) == 1;
        dbg_lock_i = $urandom_range(0, 3) == 0;
        dbg_we_i   = $urandom_range(0, 1) == 1;
        dbg_wem_i  = 4'($urandom);
        dbg_addr_i = 32'($urandom_range(0, 15)) << 2;
        dbg_din_i  = $urandom;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
